// File: rtl/scu_pkg.sv
// rtl/scu_pkg.sv - shared state encodings and default timing for the step control unit.
package scu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FIRE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    // 5 ms debounce and 4 Hz auto-step at a 100 MHz board clock
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_DB_W            = 20;
    localparam int DEF_RUN_DIV         = 25000000;
    localparam int DEF_RUN_W           = 25;
    localparam int DEF_STEP_W          = 16;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus hold-time debounce for a raw push button.
module btn_debounce
    import scu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = DEF_DB_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] cnt;

    // Any sample that agrees with the accepted level restarts the hold count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - turns a debounced button or an auto-step divider into one-cycle step strobes.
module step_pulse_gen
    import scu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_W            = DEF_DB_W,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int RUN_W           = DEF_RUN_W,
    parameter int STEP_W          = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PushButton,
    input  logic              runMode,
    input  logic              halt,
    output logic              step,
    output logic              btnLevel,
    output logic [STEP_W-1:0] stepCount
);

    localparam logic [RUN_W-1:0] DIV_LAST = RUN_W'(RUN_DIV - 1);

    logic [1:0]       state;
    logic [RUN_W-1:0] divider;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (PushButton),
        .level (btnLevel)
    );

    // The strobe is registered on the edge that enters S_FIRE, so step is high
    // exactly while the FSM sits in S_FIRE; S_FIRE only retires the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            divider   <= '0;
            step      <= 1'b0;
            stepCount <= '0;
        end else begin
            step <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (runMode) begin
                        state   <= S_RUN;
                        divider <= '0;
                    end else if (btnLevel) begin
                        if (halt) begin
                            state <= S_HOLD;
                        end else begin
                            state     <= S_FIRE;
                            step      <= 1'b1;
                            stepCount <= stepCount + STEP_W'(1);
                        end
                    end
                end
                S_FIRE: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!btnLevel) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    // Leaving run mode drops any step that would fall on the same edge.
                    if (!runMode) begin
                        state <= btnLevel ? S_HOLD : S_IDLE;
                    end else if (!halt) begin
                        if (divider == DIV_LAST) begin
                            divider   <= '0;
                            step      <= 1'b1;
                            stepCount <= stepCount + STEP_W'(1);
                        end else begin
                            divider <= divider + RUN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - directed and randomized checks of step_pulse_gen against a flag-based reference.
module tb_step_pulse_gen;

    localparam int DB  = 8;
    localparam int DBW = 4;
    localparam int RD  = 5;
    localparam int RW  = 3;
    localparam int SW  = 8;
    localparam int CNT_MOD = 1 << SW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          PushButton = 1'b0;
    logic          runMode = 1'b0;
    logic          halt = 1'b0;
    logic          step;
    logic          btnLevel;
    logic [SW-1:0] stepCount;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .DB_W            (DBW),
        .RUN_DIV         (RD),
        .RUN_W           (RW),
        .STEP_W          (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PushButton (PushButton),
        .runMode    (runMode),
        .halt       (halt),
        .step       (step),
        .btnLevel   (btnLevel),
        .stepCount  (stepCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: button history, a disagreement run length, and mode flags.
    bit m_s1, m_s2, m_lvl;
    int m_disagree;
    bit m_running, m_fired, m_need_rel, m_step;
    int m_phase, m_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= 0; m_s2 <= 0; m_lvl <= 0; m_disagree <= 0;
            m_running <= 0; m_fired <= 0; m_need_rel <= 0; m_step <= 0;
            m_phase <= 0; m_count <= 0;
        end else begin
            m_s1 <= PushButton;
            m_s2 <= m_s1;
            if (m_s2 != m_lvl && m_disagree == DB - 1) begin
                m_lvl <= m_s2;
                m_disagree <= 0;
            end else begin
                m_disagree <= (m_s2 != m_lvl) ? m_disagree + 1 : 0;
            end
            m_step  <= 0;
            m_fired <= 0;
            if (m_running) begin
                if (!runMode) begin
                    m_running  <= 0;
                    m_need_rel <= m_lvl;
                end else if (!halt) begin
                    if (m_phase + 1 == RD) begin
                        m_step  <= 1;
                        m_count <= (m_count + 1) % CNT_MOD;
                        m_phase <= 0;
                    end else begin
                        m_phase <= m_phase + 1;
                    end
                end
            end else if (m_fired) begin
                m_need_rel <= 1;
            end else if (m_need_rel) begin
                if (!m_lvl) m_need_rel <= 0;
            end else if (runMode) begin
                m_running <= 1;
                m_phase   <= 0;
            end else if (m_lvl) begin
                if (halt) begin
                    m_need_rel <= 1;
                end else begin
                    m_step  <= 1;
                    m_fired <= 1;
                    m_count <= (m_count + 1) % CNT_MOD;
                end
            end
        end
    end

    bit chk_en = 0;
    bit prev_step = 0;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            tests++;
            if (step !== m_step || btnLevel !== m_lvl || stepCount !== SW'(m_count)) begin
                fails++;
                $display("FAIL cycle_model cyc=%0d: got step=%b lvl=%b cnt=%0d, expected step=%b lvl=%b cnt=%0d",
                         cyc, step, btnLevel, stepCount, m_step, m_lvl, m_count);
            end
            tests++;
            if (prev_step && step) begin
                fails++;
                $display("FAIL no_back_to_back cyc=%0d: got two consecutive steps, expected gap", cyc);
            end
            prev_step = step;
        end else begin
            prev_step = 0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the edge count at the first negedge where the chosen output is 1, or -1.
    task automatic wait_high(input bit on_step, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((on_step ? step : btnLevel) == 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t_press, t_at, c0, n, first, last, halted_steps, r_edge, hold_left;
        bit lvl_seen, saw_ff, wrapped;

        tick(3);
        check("reset_step", step, 0);
        check("reset_level", btnLevel, 0);
        check("reset_count", stepCount, 0);
        reset = 1'b0;
        chk_en = 1;
        tick(5);

        // Clean press: latency from first sampling edge
        PushButton = 1'b1;
        t_press = cyc + 1;
        wait_high(0, 30, t_at);
        check("t1_level_latency", t_at - t_press, DB + 1);
        wait_high(1, 5, t_at);
        check("t1_step_latency", t_at - t_press, DB + 2);
        tick(38);
        check("t1_count", stepCount, 1);
        PushButton = 1'b0;
        tick(20);

        // Bounce shorter than the debounce window is never accepted
        lvl_seen = 0;
        for (int i = 0; i < 30; i++) begin
            PushButton = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (btnLevel) lvl_seen = 1;
        end
        check("t2_no_level_while_bouncing", lvl_seen, 0);
        PushButton = 1'b1;
        tick(30);
        check("t2_count", stepCount, 2);
        PushButton = 1'b0;
        tick(20);

        // Run mode: steps every RD cycles, button ignored
        c0 = m_count;
        runMode = 1'b1;
        t_press = cyc + 1;
        n = 0; first = -1; last = -1;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            if (step) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (i == 3) PushButton = 1'b1;
            if (i == 15) PushButton = 1'b0;
        end
        runMode = 1'b0;
        check("t3_steps", n, 4);
        check("t3_first_offset", first - t_press, RD);
        check("t3_span", last - first, 3 * RD);
        tick(30);
        check("t3_count", stepCount, (c0 + 4) % CNT_MOD);

        // halt freezes the divider mid-count
        runMode = 1'b1;
        n = 0; first = -1; last = -1; halted_steps = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (step) begin
                if (halt) halted_steps++;
                if (n == 0) first = cyc;
                if (n == 1) last = cyc;
                n++;
            end
            if (i == 7) halt = 1'b1;
            if (i == 14) halt = 1'b0;
        end
        runMode = 1'b0;
        check("t4_no_step_in_halt", halted_steps, 0);
        check("t4_spacing", last - first, RD + 7);
        tick(15);

        // Reset during the strobe cycle
        PushButton = 1'b1;
        wait_high(1, 40, t_at);
        check("t5_step_seen", (t_at > 0) ? 1 : 0, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_step", step, 0);
        check("t5_count", stepCount, 0);
        @(negedge clk);
        reset = 1'b0;
        r_edge = cyc + 1;
        wait_high(1, 40, t_at);
        check("t5_restep_latency", t_at - r_edge, DB + 2);
        check("t5_count_after", stepCount, 1);
        PushButton = 1'b0;
        tick(20);

        // Counter wrap through run mode
        runMode = 1'b1;
        saw_ff = 0; wrapped = 0;
        for (int i = 0; i < 2000 && !wrapped; i++) begin
            @(negedge clk);
            if (saw_ff && step) wrapped = (stepCount == '0);
            if (stepCount == SW'(CNT_MOD - 1)) saw_ff = 1;
        end
        runMode = 1'b0;
        check("t6_wrap", wrapped, 1);
        tick(10);

        // Randomized inputs, checked every cycle against the reference
        hold_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_left == 0) begin
                PushButton = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 14);
            end else begin
                hold_left--;
            end
            if ($urandom_range(0, 59) == 0) runMode = ~runMode;
            if ($urandom_range(0, 24) == 0) halt = ~halt;
            if (i == 2000) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
